kernel_coef_gen: RTL and testbench

Sequential, parametrised generator for scaled 3x3 edge-detection kernels (X and Y gradient) in the image-processing datapath. On a start pulse it latches a scale factor and kernel mode. It then emits all 18 signed coefficients in raster order on a valid/ready stream into the convolution engine's coefficient loader. In parallel it fills a registered kernel bank that downstream logic may read once `kernel_valid` is high.

---
 rtl/kgen_pkg.sv | 56 +++++
 rtl/kgen_coef_rom.sv | 14 +
 rtl/kernel_coef_gen.sv | 129 ++++++++++++
 tb/tb_kernel_coef_gen.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/kgen_pkg.sv
// Shared types and the base-coefficient lookup for the edge-kernel generator.
// Scharr tables exist only when KGEN_SCHARR_EN is defined; otherwise mode 2 aliases Sobel.
package kgen_pkg;

    typedef enum logic [1:0] {
        MODE_SOBEL   = 2'd0,
        MODE_PREWITT = 2'd1,
        MODE_SCHARR  = 2'd2,
        MODE_RSVD    = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GEN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [4:0] LAST_ELEM = 5'd17;
    localparam logic [4:0] N_TAP     = 5'd9;

    // Every kernel is separable: a difference term [1 0 -1] along one axis times a smoothing term.
    function automatic logic signed [4:0] base_coef(input logic axis, input mode_e mode,
                                                    input logic [3:0] idx);
        logic [3:0]        rc;
        logic [1:0]        d_pos;
        logic [1:0]        s_pos;
        logic signed [4:0] diff;
        logic signed [4:0] smooth;
        case (idx)
            4'd0:    rc = 4'b00_00;
            4'd1:    rc = 4'b00_01;
            4'd2:    rc = 4'b00_10;
            4'd3:    rc = 4'b01_00;
            4'd4:    rc = 4'b01_01;
            4'd5:    rc = 4'b01_10;
            4'd6:    rc = 4'b10_00;
            4'd7:    rc = 4'b10_01;
            4'd8:    rc = 4'b10_10;
            default: rc = 4'b00_00;
        endcase
        d_pos = axis ? rc[3:2] : rc[1:0];
        s_pos = axis ? rc[1:0] : rc[3:2];
        if (d_pos == 2'd0)      diff = 5'sd1;
        else if (d_pos == 2'd2) diff = -5'sd1;
        else                    diff = 5'sd0;
        case (mode)
            MODE_PREWITT: smooth = 5'sd1;
`ifdef KGEN_SCHARR_EN
            MODE_SCHARR:  smooth = (s_pos == 2'd1) ? 5'sd10 : 5'sd3;
`endif
            default:      smooth = (s_pos == 2'd1) ? 5'sd2 : 5'sd1;
        endcase
        return diff * smooth;
    endfunction

endpackage

// File: rtl/kgen_coef_rom.sv
// Combinational base-coefficient lookup (axis, mode, raster index -> signed 5-bit).
// Contents depend on KGEN_SCHARR_EN through kgen_pkg::base_coef.
module kgen_coef_rom
    import kgen_pkg::*;
(
    input  logic              axis,
    input  mode_e             mode,
    input  logic [3:0]        idx,
    output logic signed [4:0] base
);

    assign base = base_coef(axis, mode, idx);

endmodule

// File: rtl/kernel_coef_gen.sv
// Streams 18 scaled edge-kernel coefficients (X then Y) and fills a registered bank.
// Optional Scharr support via KGEN_SCHARR_EN.  States: IDLE wait start | GEN stream | DONE pulse done.
module kernel_coef_gen
    import kgen_pkg::*;
#(
    parameter int SCALE_W = 4,
    parameter int COEF_W  = 9
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [SCALE_W-1:0]            scale,
    input  logic [1:0]                    mode,
    output logic                          busy,
    output logic                          done,
    output logic                          coef_valid,
    input  logic                          coef_ready,
    output logic [COEF_W-1:0]             coef_data,
    output logic                          coef_axis,
    output logic [3:0]                    coef_idx,
    output logic [0:2][0:2][COEF_W-1:0]   outx,
    output logic [0:2][0:2][COEF_W-1:0]   outy,
    output logic                          kernel_valid
);

    localparam int PROD_W = SCALE_W + 6;

    state_e              state;
    logic [4:0]          cnt;
    logic [SCALE_W-1:0]  scale_q;
    mode_e               mode_q;

    logic [4:0]               lk_cnt;
    logic                     lk_axis;
    logic [3:0]               lk_idx;
    mode_e                    lk_mode;
    logic [SCALE_W-1:0]       lk_scale;
    logic signed [4:0]        base;
    logic signed [PROD_W-1:0] prod_full;
    logic [COEF_W-1:0]        coef_next;

    // Look ahead to the element that will be presented after the next edge.
    always_comb begin
        lk_cnt    = (state == ST_IDLE) ? 5'd0 : cnt + 5'd1;
        lk_axis   = (lk_cnt >= N_TAP);
        lk_idx    = lk_axis ? 4'(lk_cnt - N_TAP) : lk_cnt[3:0];
        lk_mode   = (state == ST_IDLE) ? mode_e'(mode) : mode_q;
        lk_scale  = (state == ST_IDLE) ? scale : scale_q;
        prod_full = PROD_W'(base) * PROD_W'($signed({1'b0, lk_scale}));
        coef_next = COEF_W'(prod_full);
    end

    kgen_coef_rom u_rom (
        .axis (lk_axis),
        .mode (lk_mode),
        .idx  (lk_idx),
        .base (base)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            scale_q      <= '0;
            mode_q       <= MODE_SOBEL;
            busy         <= 1'b0;
            done         <= 1'b0;
            coef_valid   <= 1'b0;
            coef_data    <= '0;
            coef_axis    <= 1'b0;
            coef_idx     <= '0;
            outx         <= '0;
            outy         <= '0;
            kernel_valid <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state        <= ST_GEN;
                        scale_q      <= scale;
                        mode_q       <= mode_e'(mode);
                        cnt          <= '0;
                        busy         <= 1'b1;
                        coef_valid   <= 1'b1;
                        kernel_valid <= 1'b0;
                        coef_data    <= coef_next;
                        coef_axis    <= lk_axis;
                        coef_idx     <= lk_idx;
                    end
                end
                ST_GEN: begin
                    if (coef_ready) begin
                        for (int r = 0; r < 3; r++) begin
                            for (int c = 0; c < 3; c++) begin
                                if (coef_idx == 4'(r * 3 + c)) begin
                                    if (coef_axis) outy[r][c] <= coef_data;
                                    else           outx[r][c] <= coef_data;
                                end
                            end
                        end
                        if (cnt == LAST_ELEM) begin
                            state        <= ST_DONE;
                            cnt          <= '0;
                            coef_valid   <= 1'b0;
                            done         <= 1'b1;
                            kernel_valid <= 1'b1;
                        end else begin
                            cnt       <= cnt + 5'd1;
                            coef_data <= coef_next;
                            coef_axis <= lk_axis;
                            coef_idx  <= lk_idx;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state      <= ST_IDLE;
                    busy       <= 1'b0;
                    coef_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_kernel_coef_gen.sv
// Self-checking bench for kernel_coef_gen: vector table, corner sequences and random runs
// against a table-based reference model (follows KGEN_SCHARR_EN like the design).
module tb_kernel_coef_gen;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    start;
    logic [3:0]              scale;
    logic [1:0]              mode;
    logic                    busy;
    logic                    done;
    logic                    coef_valid;
    logic                    coef_ready;
    logic [8:0]              coef_data;
    logic                    coef_axis;
    logic [3:0]              coef_idx;
    logic [0:2][0:2][8:0]    outx;
    logic [0:2][0:2][8:0]    outy;
    logic                    kernel_valid;

    int n_checks = 0;
    int n_errors = 0;

    int base_tbl [3][2][9];

    typedef struct {
        int md;
        int sc;
        int pat;
        int x10;
        int x12;
        int y01;
    } vec_t;

    vec_t vecs [9];

    kernel_coef_gen #(.SCALE_W(4), .COEF_W(9)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .scale        (scale),
        .mode         (mode),
        .busy         (busy),
        .done         (done),
        .coef_valid   (coef_valid),
        .coef_ready   (coef_ready),
        .coef_data    (coef_data),
        .coef_axis    (coef_axis),
        .coef_idx     (coef_idx),
        .outx         (outx),
        .outy         (outy),
        .kernel_valid (kernel_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int eff_mode(input int md);
        if (md == 1) return 1;
`ifdef KGEN_SCHARR_EN
        if (md == 2) return 2;
`endif
        return 0;
    endfunction

    function automatic int model(input int md, input int ax, input int idx, input int sc);
        return base_tbl[eff_mode(md)][ax][idx] * sc;
    endfunction

    function automatic int s9(input logic [8:0] v);
        return int'($signed(v));
    endfunction

    task automatic run_seq(input int md, input int sc, input int pat, input int inj_at,
                           input int abort_at);
        int k = 0;
        int edges = 0;
        int stalls = 0;
        bit have_prev = 0;
        bit phase = 1;
        bit rdy;
        logic [8:0] p_data;
        logic       p_axis;
        logic [3:0] p_idx;
        int e_ax;
        int e_idx;

        @(negedge clk);
        start = 1'b1;
        scale = 4'(sc);
        mode  = 2'(md);
        @(posedge clk);
        while (k < 18 && edges < 200) begin
            @(negedge clk);
            start = 1'b0;
            if (k == inj_at) begin
                start = 1'b1;
                scale = 4'd7;
                mode  = 2'd1;
            end
            if (k == abort_at) begin
                rst = 1'b1;
                #1;
                chk("abort_busy", int'(busy), 0);
                chk("abort_done", int'(done), 0);
                chk("abort_valid", int'(coef_valid), 0);
                chk("abort_kvalid", int'(kernel_valid), 0);
                chk("abort_data", int'(coef_data), 0);
                chk("abort_axis", int'(coef_axis), 0);
                chk("abort_idx", int'(coef_idx), 0);
                chk("abort_outx_zero", int'(outx == '0), 1);
                chk("abort_outy_zero", int'(outy == '0), 1);
                repeat (2) @(posedge clk);
                @(negedge clk);
                rst = 1'b0;
                coef_ready = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    chk("abort_no_done", int'(done), 0);
                end
                return;
            end
            case (pat)
                0:       rdy = 1'b1;
                1:       rdy = phase;
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            phase = ~phase;
            coef_ready = rdy;
            chk("valid_in_gen", int'(coef_valid), 1);
            chk("kvalid_low_in_gen", int'(kernel_valid), 0);
            chk("busy_in_gen", int'(busy), 1);
            if (have_prev) begin
                chk("stall_data_stable", s9(coef_data), s9(p_data));
                chk("stall_axis_stable", int'(coef_axis), int'(p_axis));
                chk("stall_idx_stable", int'(coef_idx), int'(p_idx));
            end
            e_ax  = k / 9;
            e_idx = k % 9;
            if (rdy) begin
                chk("elem_axis", int'(coef_axis), e_ax);
                chk("elem_idx", int'(coef_idx), e_idx);
                chk("elem_data", s9(coef_data), model(md, e_ax, e_idx, sc));
                k++;
                have_prev = 0;
            end else begin
                stalls++;
                p_data = coef_data;
                p_axis = coef_axis;
                p_idx  = coef_idx;
                have_prev = 1;
            end
            @(posedge clk);
            edges++;
        end
        chk("sequence_completed", k, 18);
        @(negedge clk);
        start = 1'b0;
        coef_ready = 1'($urandom_range(0, 1));
        chk("done_latency", edges, 18 + stalls);
        chk("done_pulse", int'(done), 1);
        chk("kvalid_at_done", int'(kernel_valid), 1);
        chk("busy_at_done", int'(busy), 1);
        chk("valid_off_at_done", int'(coef_valid), 0);
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                chk("bank_x", s9(outx[r][c]), model(md, 0, r * 3 + c, sc));
                chk("bank_y", s9(outy[r][c]), model(md, 1, r * 3 + c, sc));
            end
        end
        @(negedge clk);
        chk("done_falls", int'(done), 0);
        chk("busy_falls", int'(busy), 0);
        chk("kvalid_holds", int'(kernel_valid), 1);
    endtask

    initial begin
        base_tbl[0][0] = '{1, 0, -1, 2, 0, -2, 1, 0, -1};
        base_tbl[0][1] = '{1, 2, 1, 0, 0, 0, -1, -2, -1};
        base_tbl[1][0] = '{1, 0, -1, 1, 0, -1, 1, 0, -1};
        base_tbl[1][1] = '{1, 1, 1, 0, 0, 0, -1, -1, -1};
        base_tbl[2][0] = '{3, 0, -3, 10, 0, -10, 3, 0, -3};
        base_tbl[2][1] = '{3, 10, 3, 0, 0, 0, -3, -10, -3};

        vecs[0] = '{md: 0, sc: 3,  pat: 0, x10: 6,  x12: -6,  y01: 6};
        vecs[1] = '{md: 1, sc: 15, pat: 1, x10: 15, x12: -15, y01: 15};
`ifdef KGEN_SCHARR_EN
        vecs[2] = '{md: 2, sc: 15, pat: 0, x10: 150, x12: -150, y01: 150};
`else
        vecs[2] = '{md: 2, sc: 15, pat: 0, x10: 30, x12: -30, y01: 30};
`endif
        vecs[3] = '{md: 3, sc: 5,  pat: 2, x10: 10, x12: -10, y01: 10};
        vecs[4] = '{md: 0, sc: 0,  pat: 2, x10: 0,  x12: 0,   y01: 0};
        vecs[5] = '{md: 1, sc: 0,  pat: 1, x10: 0,  x12: 0,   y01: 0};
        vecs[6] = '{md: 2, sc: 0,  pat: 0, x10: 0,  x12: 0,   y01: 0};
        vecs[7] = '{md: 3, sc: 0,  pat: 2, x10: 0,  x12: 0,   y01: 0};
        vecs[8] = '{md: 1, sc: 1,  pat: 2, x10: 1,  x12: -1,  y01: 1};

        rst = 1'b1;
        start = 1'b0;
        scale = '0;
        mode = '0;
        coef_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_valid", int'(coef_valid), 0);
        chk("rst_kvalid", int'(kernel_valid), 0);
        chk("rst_data", int'(coef_data), 0);
        chk("rst_axis", int'(coef_axis), 0);
        chk("rst_idx", int'(coef_idx), 0);
        chk("rst_outx", int'(outx == '0), 1);
        chk("rst_outy", int'(outy == '0), 1);
        rst = 1'b0;

        for (int v = 0; v < 9; v++) begin
            run_seq(vecs[v].md, vecs[v].sc, vecs[v].pat, -1, -1);
            chk("vec_x10", s9(outx[1][0]), vecs[v].x10);
            chk("vec_x12", s9(outx[1][2]), vecs[v].x12);
            chk("vec_y01", s9(outy[0][1]), vecs[v].y01);
        end

        // start while busy must not disturb the latched scale or mode
        run_seq(0, 3, 0, 5, -1);
        chk("ignored_start_x12", s9(outx[1][2]), -6);

        // reset mid-stream, then a clean sequence
        run_seq(1, 9, 0, -1, 10);
        run_seq(1, 9, 2, -1, -1);

        for (int i = 0; i < 8; i++) begin
            run_seq(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
                    int'($urandom_range(0, 2)), -1, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish before time limit");
        $fatal(1, "timeout");
    end

endmodule
